// File: rtl/bit_unstuff_rx_if.sv
// Handshake and status bundle between the NRZI decoder side and bit_unstuff_rx.
// master drives the qualified bit stream; slave (the unstuffer) drives payload and error status.
interface bit_unstuff_rx_if #(
    parameter int RUN_LEN = 6,
    parameter int CNT_W   = 8
);
    localparam int RUN_W = $clog2(RUN_LEN + 1);

    logic             Bit_Unstuff_Pkt_Start;
    logic             Bit_Unstuff_Eop;
    logic             Bit_Unstuff_Valid_In;
    logic             Bit_Unstuff_Data_In;
    logic             Bit_Unstuff_Valid_Out;
    logic             Bit_Unstuff_Data_Out;
    logic             Bit_Unstuff_Error_Flag;
    logic             Bit_Unstuff_Error_Sticky;
    logic [CNT_W-1:0] Bit_Unstuff_Error_Count;
    logic [RUN_W-1:0] Bit_Unstuff_Run_Count;

    modport master (
        output Bit_Unstuff_Pkt_Start, Bit_Unstuff_Eop, Bit_Unstuff_Valid_In, Bit_Unstuff_Data_In,
        input  Bit_Unstuff_Valid_Out, Bit_Unstuff_Data_Out, Bit_Unstuff_Error_Flag,
               Bit_Unstuff_Error_Sticky, Bit_Unstuff_Error_Count, Bit_Unstuff_Run_Count
    );

    modport slave (
        input  Bit_Unstuff_Pkt_Start, Bit_Unstuff_Eop, Bit_Unstuff_Valid_In, Bit_Unstuff_Data_In,
        output Bit_Unstuff_Valid_Out, Bit_Unstuff_Data_Out, Bit_Unstuff_Error_Flag,
               Bit_Unstuff_Error_Sticky, Bit_Unstuff_Error_Count, Bit_Unstuff_Run_Count
    );
endinterface

// File: rtl/bit_unstuff_rx.sv
// USB receive bit-unstuffer: drops the zero after RUN_LEN ones and flags stuff errors.
// Define BIT_UNSTUFF_ERR_CNT_EN to build the saturating Error_Count register; otherwise it reads 0.
module bit_unstuff_rx #(
    parameter int RUN_LEN = 6,
    parameter int CNT_W   = 8
) (
    input  logic              Bit_Unstuff_Clk,
    input  logic              Bit_Unstuff_Reset,
    bit_unstuff_rx_if.slave   bus
);
    localparam int RUN_W = $clog2(RUN_LEN + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_STUFF  = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             vout_q, vout_d;
    logic             dout_q, dout_d;
    logic             eflag_q, eflag_d;
    logic             sticky_q, sticky_d;

    logic [1:0]       cur_state;
    logic [RUN_W-1:0] cur_run;
    logic [RUN_W-1:0] run_inc;

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        vout_d   = 1'b0;
        dout_d   = dout_q;
        eflag_d  = 1'b0;
        sticky_d = sticky_q;

        // Pkt_Start takes effect before a same-cycle bit so that bit sees a fresh, zero run.
        cur_state = state_q;
        cur_run   = run_q;
        if (bus.Bit_Unstuff_Pkt_Start) begin
            cur_state = ST_ACTIVE;
            cur_run   = '0;
            state_d   = ST_ACTIVE;
            run_d     = '0;
            sticky_d  = 1'b0;
        end
        run_inc = cur_run + 1'b1;

        if (bus.Bit_Unstuff_Valid_In) begin
            case (cur_state)
                ST_ACTIVE: begin
                    vout_d = 1'b1;
                    dout_d = bus.Bit_Unstuff_Data_In;
                    if (bus.Bit_Unstuff_Data_In) begin
                        run_d   = run_inc;
                        state_d = (run_inc == RUN_W'(RUN_LEN)) ? ST_STUFF : ST_ACTIVE;
                    end else begin
                        run_d   = '0;
                        state_d = ST_ACTIVE;
                    end
                end
                ST_STUFF: begin
                    run_d = '0;
                    if (bus.Bit_Unstuff_Data_In) begin
                        eflag_d  = 1'b1;
                        sticky_d = 1'b1;
                        state_d  = ST_ERROR;
                    end else begin
                        state_d  = ST_ACTIVE;
                    end
                end
                default: ;
            endcase
        end

        // End of packet closes the packet after any same-cycle bit; a coincident Pkt_Start wins.
        if (bus.Bit_Unstuff_Eop && !bus.Bit_Unstuff_Pkt_Start) begin
            state_d = ST_IDLE;
            run_d   = '0;
        end
    end

    always_ff @(posedge Bit_Unstuff_Clk) begin
        if (Bit_Unstuff_Reset) begin
            state_q  <= ST_IDLE;
            run_q    <= '0;
            vout_q   <= 1'b0;
            dout_q   <= 1'b0;
            eflag_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            vout_q   <= vout_d;
            dout_q   <= dout_d;
            eflag_q  <= eflag_d;
            sticky_q <= sticky_d;
        end
    end

`ifdef BIT_UNSTUFF_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (eflag_d && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge Bit_Unstuff_Clk) begin
        if (Bit_Unstuff_Reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign bus.Bit_Unstuff_Error_Count = cnt_q;
`else
    assign bus.Bit_Unstuff_Error_Count = '0;
`endif

    assign bus.Bit_Unstuff_Valid_Out    = vout_q;
    assign bus.Bit_Unstuff_Data_Out     = dout_q;
    assign bus.Bit_Unstuff_Error_Flag   = eflag_q;
    assign bus.Bit_Unstuff_Error_Sticky = sticky_q;
    assign bus.Bit_Unstuff_Run_Count    = run_q;
endmodule

// File: tb/tb_bit_unstuff_rx.sv
// Directed bench for bit_unstuff_rx (RUN_LEN=6, CNT_W=8); expected values are hand-derived.
module tb_bit_unstuff_rx;
    localparam int RUN_LEN = 6;
    localparam int CNT_W   = 8;
`ifdef BIT_UNSTUFF_ERR_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bit_unstuff_rx_if #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) bus ();

    bit_unstuff_rx #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
        .Bit_Unstuff_Clk   (clk),
        .Bit_Unstuff_Reset (rst),
        .bus               (bus)
    );

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge that registers them.
    task automatic tick(input logic ps, input logic eop, input logic v, input logic d);
        bus.Bit_Unstuff_Pkt_Start = ps;
        bus.Bit_Unstuff_Eop       = eop;
        bus.Bit_Unstuff_Valid_In  = v;
        bus.Bit_Unstuff_Data_In   = d;
        @(posedge clk);
        #1;
        $display("t=%0t ps=%0d eop=%0d v=%0d d=%0d -> vo=%0d do=%0d ef=%0d es=%0d ec=%0d run=%0d",
                 $time, ps, eop, v, d, bus.Bit_Unstuff_Valid_Out, bus.Bit_Unstuff_Data_Out,
                 bus.Bit_Unstuff_Error_Flag, bus.Bit_Unstuff_Error_Sticky,
                 bus.Bit_Unstuff_Error_Count, bus.Bit_Unstuff_Run_Count);
    endtask

    initial begin
        int bits[8];
        int expv[8];
        int expr[8];
        int npass;
        int errs;

        bus.Bit_Unstuff_Pkt_Start = 1'b0;
        bus.Bit_Unstuff_Eop       = 1'b0;
        bus.Bit_Unstuff_Valid_In  = 1'b0;
        bus.Bit_Unstuff_Data_In   = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vout",   bus.Bit_Unstuff_Valid_Out, 0);
        chk("rst_dout",   bus.Bit_Unstuff_Data_Out, 0);
        chk("rst_flag",   bus.Bit_Unstuff_Error_Flag, 0);
        chk("rst_sticky", bus.Bit_Unstuff_Error_Sticky, 0);
        chk("rst_count",  bus.Bit_Unstuff_Error_Count, 0);
        chk("rst_run",    bus.Bit_Unstuff_Run_Count, 0);
        rst = 1'b0;

        tick(0, 0, 1, 1);
        chk("idle_ignore", bus.Bit_Unstuff_Valid_Out, 0);

        // Normal stuffing: 1x6, stuffed 0 dropped, then a payload 1.
        bits = '{1, 1, 1, 1, 1, 1, 0, 1};
        expv = '{1, 1, 1, 1, 1, 1, 0, 1};
        expr = '{1, 2, 3, 4, 5, 6, 0, 1};
        npass = 0;
        tick(1, 0, 0, 0);
        chk("t1_run0", bus.Bit_Unstuff_Run_Count, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 1, bits[i][0]);
            chk("t1_vout", bus.Bit_Unstuff_Valid_Out, expv[i]);
            chk("t1_dout", bus.Bit_Unstuff_Data_Out, 1);
            chk("t1_run",  bus.Bit_Unstuff_Run_Count, expr[i]);
            chk("t1_flag", bus.Bit_Unstuff_Error_Flag, 0);
            if (bus.Bit_Unstuff_Valid_Out) npass++;
        end
        chk("t1_npass", npass, 7);
        tick(0, 1, 0, 0);

        // Stuff error on the 7th one.
        errs = 0;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick(0, 0, 1, 1);
        tick(0, 0, 1, 1);
        errs++;
        chk("t2_flag",   bus.Bit_Unstuff_Error_Flag, 1);
        chk("t2_vout",   bus.Bit_Unstuff_Valid_Out, 0);
        chk("t2_sticky", bus.Bit_Unstuff_Error_Sticky, 1);
        chk("t2_count",  bus.Bit_Unstuff_Error_Count, errs * CNT_EN);
        chk("t2_run",    bus.Bit_Unstuff_Run_Count, 0);
        tick(0, 0, 0, 0);
        chk("t2_flag_once", bus.Bit_Unstuff_Error_Flag, 0);
        chk("t2_sticky_hold", bus.Bit_Unstuff_Error_Sticky, 1);
        tick(0, 0, 1, 0);
        chk("t2_err_drop0", bus.Bit_Unstuff_Valid_Out, 0);
        tick(0, 0, 1, 1);
        chk("t2_err_drop1", bus.Bit_Unstuff_Valid_Out, 0);
        chk("t2_err_noflag", bus.Bit_Unstuff_Error_Flag, 0);
        tick(0, 1, 0, 0);
        chk("t2_eop_sticky", bus.Bit_Unstuff_Error_Sticky, 1);
        tick(1, 0, 0, 0);
        chk("t2_pkt_clr", bus.Bit_Unstuff_Error_Sticky, 0);

        // Drive the counter up to saturation.
        while (errs < 255) begin
            for (int i = 0; i < 7; i++) tick(0, 0, 1, 1);
            errs++;
            tick(1, 0, 0, 0);
        end
        chk("t3_count255", bus.Bit_Unstuff_Error_Count, 255 * CNT_EN);
        for (int i = 0; i < 7; i++) tick(0, 0, 1, 1);
        chk("t3_flag_sat", bus.Bit_Unstuff_Error_Flag, 1);
        chk("t3_count_sat", bus.Bit_Unstuff_Error_Count, 255 * CNT_EN);
        tick(0, 1, 0, 0);

        // Run is cleared between packets: 1x5, Eop, Pkt_Start, 1x2 all pass.
        npass = 0;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 1, 1);
            if (bus.Bit_Unstuff_Valid_Out) npass++;
        end
        tick(0, 1, 0, 0);
        tick(1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            tick(0, 0, 1, 1);
            if (bus.Bit_Unstuff_Valid_Out) npass++;
        end
        chk("t4_npass", npass, 7);
        chk("t4_run", bus.Bit_Unstuff_Run_Count, 2);
        tick(0, 1, 0, 0);

        // Pkt_Start with a bit on top of a run of 5: bit counts against a zero run.
        tick(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 1);
        chk("t5_run5", bus.Bit_Unstuff_Run_Count, 5);
        tick(1, 0, 1, 1);
        chk("t5_vout", bus.Bit_Unstuff_Valid_Out, 1);
        chk("t5_run1", bus.Bit_Unstuff_Run_Count, 1);
        npass = 0;
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 1, 1);
            if (bus.Bit_Unstuff_Valid_Out) npass++;
        end
        chk("t5_npass", npass, 5);
        chk("t5_run6", bus.Bit_Unstuff_Run_Count, 6);
        tick(0, 0, 1, 0);
        chk("t5_stuff_drop", bus.Bit_Unstuff_Valid_Out, 0);
        chk("t5_run_clr", bus.Bit_Unstuff_Run_Count, 0);

        // Eop with a bit: bit passes, then IDLE.
        tick(0, 1, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 1, 1, 1);
        chk("t6_vout", bus.Bit_Unstuff_Valid_Out, 1);
        chk("t6_run", bus.Bit_Unstuff_Run_Count, 0);
        tick(0, 0, 1, 1);
        chk("t6_idle", bus.Bit_Unstuff_Valid_Out, 0);

        // Eop and Pkt_Start together: Pkt_Start wins.
        tick(1, 1, 0, 0);
        tick(0, 0, 1, 1);
        chk("t7_vout", bus.Bit_Unstuff_Valid_Out, 1);
        chk("t7_run", bus.Bit_Unstuff_Run_Count, 1);

        // Reset while in STUFF.
        tick(0, 1, 0, 0);
        tick(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick(0, 0, 1, 1);
        chk("t8_run6", bus.Bit_Unstuff_Run_Count, 6);
        rst = 1'b1;
        tick(0, 0, 1, 1);
        chk("t8_vout", bus.Bit_Unstuff_Valid_Out, 0);
        chk("t8_dout", bus.Bit_Unstuff_Data_Out, 0);
        chk("t8_flag", bus.Bit_Unstuff_Error_Flag, 0);
        chk("t8_sticky", bus.Bit_Unstuff_Error_Sticky, 0);
        chk("t8_count", bus.Bit_Unstuff_Error_Count, 0);
        chk("t8_run", bus.Bit_Unstuff_Run_Count, 0);
        rst = 1'b0;
        tick(0, 0, 1, 1);
        chk("t8_ign1", bus.Bit_Unstuff_Valid_Out, 0);
        chk("t8_noerr", bus.Bit_Unstuff_Error_Flag, 0);
        tick(0, 0, 1, 0);
        chk("t8_ign0", bus.Bit_Unstuff_Valid_Out, 0);
        tick(1, 0, 1, 1);
        chk("t8_restart", bus.Bit_Unstuff_Valid_Out, 1);
        chk("t8_restart_run", bus.Bit_Unstuff_Run_Count, 1);
        tick(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
